mmio_interconnect: RTL

Parametrised MMIO interconnect between the CPU memory port and N memory-mapped slaves (BRAM, GPIO, future SPI flash and others). It decodes the request address against per-slave base/mask windows, latches the request, drives exactly one slave select, and waits for that slave's ready handshake. It returns read data with a one-cycle response pulse, and flags accesses to unmapped addresses and, optionally, slave timeouts as bus errors. Response routing uses the latched slave index, so read data always belongs to the address that issued it.

---
 rtl/mmio_pkg.sv | 25 ++
 rtl/mmio_addr_decode.sv | 31 +++
 rtl/mmio_interconnect.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO interconnect: FSM state type, default
// BRAM/GPIO address windows and the base/mask window-match helper.
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mmio_state_t;

    // Widest address the match helper handles; narrower addresses are zero-extended.
    localparam int MAX_ADDR_W = 64;

    localparam logic [31:0] BRAM_BASE = 32'h0000_0000;
    localparam logic [31:0] BRAM_MASK = 32'hFFFF_FE00;
    localparam logic [31:0] GPIO_BASE = 32'hFFFF_FFF0;
    localparam logic [31:0] GPIO_MASK = 32'hFFFF_FFF0;

    function automatic logic slave_hit(input logic [MAX_ADDR_W-1:0] addr,
                                       input logic [MAX_ADDR_W-1:0] base,
                                       input logic [MAX_ADDR_W-1:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational base/mask address decoder; when windows overlap the lowest
// slave index wins.
module mmio_addr_decode
    import mmio_pkg::*;
#(
    parameter int                           NUM_SLAVES = 2,
    parameter int                           ADDR_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0,
    parameter int                           IDX_W      = 1
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_o,
    output logic [IDX_W-1:0]  idx_o
);

    // Scan from the top down so the lowest matching index is the last one written.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (slave_hit(MAX_ADDR_W'(addr_i),
                          MAX_ADDR_W'(SLAVE_BASE[i*ADDR_W +: ADDR_W]),
                          MAX_ADDR_W'(SLAVE_MASK[i*ADDR_W +: ADDR_W]))) begin
                hit_o = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mmio_interconnect.sv
// MMIO interconnect: decodes a CPU request to one of NUM_SLAVES windows, holds it
// until the selected slave is ready, then returns a one-cycle response.
// Define MMIO_TIMEOUT_EN to build the ACCESS timeout counter.
module mmio_interconnect
    import mmio_pkg::*;
#(
    parameter int                           NUM_SLAVES     = 2,
    parameter int                           ADDR_W         = 32,
    parameter int                           DATA_W         = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE     = {GPIO_BASE, BRAM_BASE},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK     = {GPIO_MASK, BRAM_MASK},
    parameter int                           TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         m_req,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic                         m_write,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic [DATA_W/8-1:0]          m_wstrb,
    output logic                         m_ready,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_err,
    output logic [NUM_SLAVES-1:0]        s_sel,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_wstrb,
    output logic                         s_write,
    input  logic [NUM_SLAVES-1:0]        s_ready,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_chk_slaves
        $error("mmio_interconnect: NUM_SLAVES must be 1..16");
    end
    if (ADDR_W < 1 || ADDR_W > MAX_ADDR_W) begin : g_chk_addr
        $error("mmio_interconnect: ADDR_W out of range");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
        $error("mmio_interconnect: TIMEOUT_CYCLES must be at least 1");
    end

    mmio_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              write_q, write_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;
    logic              expired;

    mmio_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK),
        .IDX_W      (IDX_W)
    ) u_decode (
        .addr_i (m_addr),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx)
    );

    // Response routing uses the latched index, never the live decode.
    assign sel_ready = s_ready[idx_q];
    assign sel_rdata = s_rdata[idx_q*DATA_W +: DATA_W];

`ifdef MMIO_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Expiry is flagged in the ACCESS cycle that brings the count to TIMEOUT_CYCLES.
    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ACCESS) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        write_d = write_q;
        idx_d   = idx_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                rdata_d = '0;
                err_d   = 1'b0;
                if (m_req) begin
                    addr_d  = m_addr;
                    wdata_d = m_wdata;
                    wstrb_d = m_wstrb;
                    write_d = m_write;
                    idx_d   = dec_idx;
                    if (dec_hit) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // A ready in the expiry cycle still completes normally.
                if (sel_ready) begin
                    state_d = RESP;
                    rdata_d = write_q ? '0 : sel_rdata;
                    err_d   = 1'b0;
                end else if (expired) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                rdata_d = '0;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        s_sel = '0;
        if (state_q == ACCESS) begin
            s_sel[idx_q] = 1'b1;
        end
    end

    assign m_ready = (state_q == RESP);
    assign m_rdata = rdata_q;
    assign m_err   = err_q;
    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;
    assign s_wstrb = wstrb_q;
    assign s_write = write_q;

endmodule
